// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder.
// The ovf signal exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder made of two half adders and an OR gate.
module serial_ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    serial_ha_cell u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    serial_ha_cell u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first, one bit per clock.
// Optional signed overflow flag: SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_if.slave        bus_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_c;

    serial_fa_cell u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus_if.start) begin
                    state_d   = RUN;
                    shift_a_d = bus_if.a;
                    shift_b_d = bus_if.b;
                    cnt_d     = '0;
                    carry_d   = 1'b0;
                    sum_d     = '0;
                    cout_d    = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d     = 1'b0;
`endif
                end
            end
            RUN: begin
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                sum_d     = {fa_s, sum_q[WIDTH-1:1]};
                carry_d   = fa_c;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB is the carry held going into this bit.
                    ovf_d   = carry_q ^ fa_c;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus_if.busy = (state_q == RUN);
    assign bus_if.done = (state_q == DONE);
    assign bus_if.sum  = sum_q;
    assign bus_if.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus_if.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Accept, then expect W busy cycles and a result; junk_at >= 0
    // pulses a stray start during that RUN cycle.
    task automatic run_op(input logic [W-1:0] op_a,
                          input logic [W-1:0] op_b,
                          input int junk_at);
        logic [W:0] full;
        full = {1'b0, op_a} + {1'b0, op_b};
        launch(op_a, op_b);
        for (int i = 0; i < W; i++) begin
            check("busy_run", bus.busy, 1);
            check("done_run", bus.done, 0);
            if (i == 0) begin
                check("sum_clr", bus.sum, 0);
                check("cout_clr", bus.cout, 0);
            end
            if (i == junk_at) begin
                bus.start = 1'b1;
                bus.a = 8'h55;
                bus.b = 8'h55;
            end
            tick();
            bus.start = 1'b0;
        end
        check("done", bus.done, 1);
        check("busy_done", bus.busy, 0);
        check("sum", bus.sum, full[W-1:0]);
        check("cout", bus.cout, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", bus.ovf,
              (op_a[W-1] == op_b[W-1]) && (full[W-1] != op_a[W-1]));
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", bus.ovf, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_done", bus.done, 0);
        end

        run_op(8'h0F, 8'h01, -1);
        tick();
        check("done_pulse", bus.done, 0);

        run_op(8'hFF, 8'h01, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sum", bus.sum, 8'h00);
            check("hold_cout", bus.cout, 1);
        end

        run_op(8'h0F, 8'h01, 3);
        run_op(8'h80, 8'h80, -1);

`ifdef SERIAL_ADDER_OVF_EN
        tick();
        run_op(8'h7F, 8'h01, -1);
        check("ovf_set", bus.ovf, 1);
        run_op(8'hFF, 8'h01, -1);
        check("ovf_clr", bus.ovf, 0);
`endif

        // Abort mid-RUN: outputs drop before the next clock edge.
        tick();
        launch(8'h12, 8'h34);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_sum", bus.sum, 0);
        check("abort_cout", bus.cout, 0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_nodone", bus.done, 0);
        end

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 5 == 0) ra = 8'hFF;
            if (n % 7 == 0) rb = 8'h80;
            run_op(ra, rb, ($urandom_range(0, 2) == 0) ?
                   int'($urandom_range(0, W - 1)) : -1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
                check("gap_idle", bus.done, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
